button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Front-end input stage for the range-hood controller. Sits between the raw board push-buttons and mode_change, which consumes menu_btn, speed_btn[2:0], clean_btn and increase_key.
- Per button: 2-FF synchronisation, counter-based debounce, single-cycle press/release pulses and long-press detection.
- Auto-repeat on increase_key only, for time setting.
- One-hot enforcement on the three speed buttons.

Parameters:
- DEBOUNCE_CYCLES, 2_000_000: consecutive cycles a synchronised input must differ from the stable level before the stable level flips (20 ms at 100 MHz). Must be ≥ 2.
- LONG_CYCLES, 100_000_000: cycles held (stable high) before the long-press pulse (1 s).
- REPEAT_CYCLES, 20_000_000: increase_key auto-repeat period after a long press (200 ms).
- CNT_W, 27: width of the debounce and hold counters. Must hold LONG_CYCLES.

Ports:
- clk  in  1  system clock, single domain
- reset  in  1  synchronous, active-high
- menu_raw  in  1  raw menu button
- speed_raw  in  3  raw speed buttons; bit i = speed level i+1
- clean_raw  in  1  raw clean button
- inc_raw  in  1  raw increase key
- menu_btn  out  1  one-cycle press pulse to mode_change
- speed_btn  out  3  one-cycle press pulses, at most one bit set per cycle
- clean_btn  out  1  one-cycle press pulse
- increase_key  out  1  one-cycle press pulse OR auto-repeat pulse
- btn_level  out  6  debounced levels {inc, clean, speed[2:0], menu}
- btn_release  out  6  one-cycle release pulses, same ordering
- btn_long  out  6  one-cycle long-press pulses, same ordering

Behaviour:
- Clocking and reset: one clock, synchronous active-high reset. All flops update on clk rising edge only.
- Reset values: while reset=1, every output is 0. Sync flops, stable levels and counters are all 0.
- Synchroniser: 2 flops per raw input. Stable-level logic sees only the second flop (sync2).
- Debounce:
  - cnt clears whenever sync2 == stable.
  - While sync2 != stable, cnt increments each cycle.
  - On the edge where cnt == DEBOUNCE_CYCLES-1 and sync2 still differs, stable flips and cnt clears.
  - Latency: the raw value must be steady from the edge that first samples it (edge 1). stable/btn_level then change on edge DEBOUNCE_CYCLES+2.
  - Any reversion of sync2 before that point clears cnt. A glitch shorter than DEBOUNCE_CYCLES cycles never changes the level.
- Edge pulses:
  - press = stable rises; release = stable falls.
  - Both are registered and asserted for exactly 1 cycle, on the same edge stable changes.
- Per-button hold FSM, states IDLE, HELD, LONG, REPEAT (REPEAT is used only for inc):
  - IDLE → HELD on stable rise; hold counter clears.
  - HELD: hold increments. When hold == LONG_CYCLES-1, btn_long pulses 1 cycle. Goes to LONG (inc goes to REPEAT instead) and hold clears.
  - LONG: holds until release; no further pulses.
  - REPEAT: hold increments. When hold == REPEAT_CYCLES-1, emit a repeat pulse and clear hold.
  - Any state → IDLE on stable fall.
- increase_key = inc press pulse OR inc repeat pulse. The two can never coincide. The long-press edge itself does not emit increase_key.
  - First repeat pulse: REPEAT_CYCLES after btn_long.
- Speed one-hot:
  - If more than one speed press pulse occurs in the same cycle, only the lowest index is forwarded on speed_btn.
  - btn_level, btn_release and btn_long for speed are not masked.
  - A speed press while another speed button is already held is forwarded normally.
- Simultaneous events across different buttons are independent; there is no cross-button priority except the speed mask.
- Reset mid-operation:
  - All state returns to 0 on the next edge.
  - A button still held after reset deasserts is treated as a fresh press and yields a press pulse DEBOUNCE_CYCLES+2 edges later.
  - No release pulse is generated by reset.
- Counters saturate; they never wrap. hold does not advance in LONG.

Decomposition:
- Shared package (hood_pkg):
  - index constants BTN_MENU=0, BTN_SPD0=1, BTN_SPD1=2, BTN_SPD2=3, BTN_CLEAN=4, BTN_INC=5, N_BTN=6
  - hold FSM state encoding
- Sub-module debounce_cell, instantiated 6 times:
  - contents: synchroniser, debounce counter, stable level, press/release, hold FSM
  - parameter REPEAT_EN, set to 1 only for inc
  - outputs: level, press, release, long, repeat
- Top level: instantiations, speed one-hot mask, increase_key OR, output vector packing.

Test Plan (DEBOUNCE_CYCLES=4, LONG_CYCLES=16, REPEAT_CYCLES=5):
- Clean press: menu_raw 0→1, steady 40 cycles.
  - btn_level[0] rises on edge 6; menu_btn high exactly 1 cycle on edge 6.
  - btn_long[0] pulses on edge 22; no other pulses.
- Glitch rejection: clean_raw high for 3 cycles, then low.
  - btn_level[4] stays 0; clean_btn never pulses.
- Bounce: inc_raw toggles 1,0,1,0,1, then steady 1.
  - Exactly one increase_key pulse, 6 edges after the final rise.
- Auto-repeat: hold inc_raw for 50 cycles.
  - increase_key pulses at press edge P, then at P+16+5, P+26, P+31, …
  - btn_long[5] at P+16; release stops pulses and gives one btn_release[5].
- Speed collision: speed_raw 000→110 in the same cycle.
  - speed_btn = 010 for 1 cycle; btn_level[3:1] = 110.
- Reset mid-hold: menu held, reset pulsed for 2 cycles at edge 10, menu still held.
  - All outputs 0 during reset; no btn_release.
  - menu_btn pulses again 6 edges after reset deasserts.

Source files
------------

// File: rtl/hood_pkg.sv
// Shared definitions for the range-hood controller front end:
// button index map and the per-button hold state machine encoding.
package hood_pkg;

  localparam int unsigned BTN_MENU  = 0;
  localparam int unsigned BTN_SPD0  = 1;
  localparam int unsigned BTN_SPD1  = 2;
  localparam int unsigned BTN_SPD2  = 3;
  localparam int unsigned BTN_CLEAN = 4;
  localparam int unsigned BTN_INC   = 5;
  localparam int unsigned N_BTN     = 6;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_LONG   = 2'd2,
    ST_REPEAT = 2'd3
  } hold_state_t;

endpackage

// File: rtl/debounce_cell.sv
// One push-button channel: 2-FF synchroniser, counter debounce, registered
// press/release pulses and a hold FSM producing long-press and auto-repeat pulses.
module debounce_cell
  import hood_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000,
  parameter int unsigned CNT_W           = 27,
  parameter bit          REPEAT_EN       = 1'b0
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic [CNT_W-1:0] r_cnt;
  logic             r_press;
  logic             r_release;

  hold_state_t      r_state;
  logic [CNT_W-1:0] r_hold;
  logic             r_long;
  logic             r_repeat;

  logic w_differs;
  logic w_flip;
  logic w_rise;
  logic w_fall;

  assign w_differs = (r_sync2 != r_stable);
  assign w_flip    = w_differs && (r_cnt == DB_LAST);
  assign w_rise    = w_flip && !r_stable;
  assign w_fall    = w_flip && r_stable;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_stable  <= 1'b0;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_stable <= !r_stable;
        r_cnt    <= '0;
      end else if (r_cnt != '1) begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_press   <= w_rise;
      r_release <= w_fall;
    end
  end

  // A falling stable level pre-empts any long/repeat pulse due on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= ST_IDLE;
      r_hold   <= '0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      if (w_fall) begin
        r_state <= ST_IDLE;
        r_hold  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_hold <= '0;
            if (w_rise) begin
              r_state <= ST_HELD;
            end
          end
          ST_HELD: begin
            if (r_hold == LONG_LAST) begin
              r_long <= 1'b1;
              r_hold <= '0;
              if (REPEAT_EN) begin
                r_state <= ST_REPEAT;
              end else begin
                r_state <= ST_LONG;
              end
            end else if (r_hold != '1) begin
              r_hold <= r_hold + 1'b1;
            end
          end
          ST_LONG: begin
            r_hold <= r_hold;
          end
          ST_REPEAT: begin
            if (r_hold == REP_LAST) begin
              r_repeat <= 1'b1;
              r_hold   <= '0;
            end else if (r_hold != '1) begin
              r_hold <= r_hold + 1'b1;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_hold  <= '0;
          end
        endcase
      end
    end
  end

  assign o_level   = r_stable;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;

endmodule

// File: rtl/button_conditioner.sv
// Raw push-button front end for mode_change: six debounced channels,
// speed press one-hot masking and increase_key auto-repeat merging.
module button_conditioner
  import hood_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 2_000_000,
  parameter int unsigned LONG_CYCLES     = 100_000_000,
  parameter int unsigned REPEAT_CYCLES   = 20_000_000,
  parameter int unsigned CNT_W           = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       menu_raw,
  input  logic [2:0] speed_raw,
  input  logic       clean_raw,
  input  logic       inc_raw,
  output logic       menu_btn,
  output logic [2:0] speed_btn,
  output logic       clean_btn,
  output logic       increase_key,
  output logic [5:0] btn_level,
  output logic [5:0] btn_release,
  output logic [5:0] btn_long
);

  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] w_level;
  logic [N_BTN-1:0] w_press;
  logic [N_BTN-1:0] w_release;
  logic [N_BTN-1:0] w_long;
  logic [N_BTN-1:0] w_repeat;
  logic [2:0]       w_spd_press;

  assign w_raw = {inc_raw, clean_raw, speed_raw, menu_raw};

  for (genvar i = 0; i < N_BTN; i++) begin : g_cell
    debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .CNT_W           (CNT_W),
      .REPEAT_EN       (i == BTN_INC)
    ) u_cell (
      .i_clk     (clk),
      .i_reset   (reset),
      .i_raw     (w_raw[i]),
      .o_level   (w_level[i]),
      .o_press   (w_press[i]),
      .o_release (w_release[i]),
      .o_long    (w_long[i]),
      .o_repeat  (w_repeat[i])
    );
  end

  // Lowest speed index wins when several speed presses land together.
  assign w_spd_press  = w_press[BTN_SPD2:BTN_SPD0];
  assign speed_btn[0] = w_spd_press[0];
  assign speed_btn[1] = w_spd_press[1] && !w_spd_press[0];
  assign speed_btn[2] = w_spd_press[2] && !w_spd_press[1] && !w_spd_press[0];

  assign menu_btn  = w_press[BTN_MENU];
  assign clean_btn = w_press[BTN_CLEAN];

  // Only the inc cell has REPEAT_EN set, so the other repeat bits stay low.
  assign increase_key = w_press[BTN_INC] || (|w_repeat);

  assign btn_level   = w_level;
  assign btn_release = w_release;
  assign btn_long    = w_long;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random bouncing,
// compared every cycle against a sample-window / elapsed-time reference model.
module tb_button_conditioner;

  localparam int DB   = 4;
  localparam int LG   = 16;
  localparam int RP   = 5;
  localparam int CW   = 8;
  localparam int NB   = 6;
  localparam int MAXE = 4096;

  logic       clk = 1'b0;
  logic       reset;
  logic       menu_raw;
  logic [2:0] speed_raw;
  logic       clean_raw;
  logic       inc_raw;
  logic       menu_btn;
  logic [2:0] speed_btn;
  logic       clean_btn;
  logic       increase_key;
  logic [5:0] btn_level;
  logic [5:0] btn_release;
  logic [5:0] btn_long;

  int n_checks = 0;
  int n_errors = 0;

  button_conditioner #(
    .DEBOUNCE_CYCLES (DB),
    .LONG_CYCLES     (LG),
    .REPEAT_CYCLES   (RP),
    .CNT_W           (CW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .menu_raw     (menu_raw),
    .speed_raw    (speed_raw),
    .clean_raw    (clean_raw),
    .inc_raw      (inc_raw),
    .menu_btn     (menu_btn),
    .speed_btn    (speed_btn),
    .clean_btn    (clean_btn),
    .increase_key (increase_key),
    .btn_level    (btn_level),
    .btn_release  (btn_release),
    .btn_long     (btn_long)
  );

  always #5 clk = ~clk;

  // Reference model state: every sample taken per edge, the level, and the press time.
  bit   hist [NB][MAXE];
  bit   m_level [NB];
  bit   m_held [NB];
  int   m_pedge [NB];
  int   n_edge = 0;
  logic [5:0] e_level, e_press, e_rel, e_long, e_rep;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n_edge);
    end
  endtask

  // Level flips when the D samples that reached the debouncer all differ from it;
  // reset discards the two samples still in the synchroniser.
  task automatic model_edge(input bit rst, input logic [5:0] raw);
    bit all_diff;
    bit s;
    int el;
    e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
    for (int b = 0; b < NB; b++) begin
      if (rst) begin
        hist[b][n_edge] = 1'b0;
        if (n_edge > 0) hist[b][n_edge-1] = 1'b0;
        m_level[b] = 1'b0;
        m_held[b]  = 1'b0;
      end else begin
        hist[b][n_edge] = raw[b];
        all_diff = 1'b1;
        for (int k = n_edge - DB - 1; k <= n_edge - 2; k++) begin
          s = (k >= 0) ? hist[b][k] : 1'b0;
          if (s == m_level[b]) all_diff = 1'b0;
        end
        if (all_diff) begin
          if (m_level[b]) e_rel[b] = 1'b1;
          else            e_press[b] = 1'b1;
          m_level[b] = !m_level[b];
        end
        if (e_press[b]) begin
          m_held[b]  = 1'b1;
          m_pedge[b] = n_edge;
        end else if (e_rel[b]) begin
          m_held[b] = 1'b0;
        end else if (m_held[b]) begin
          el = n_edge - m_pedge[b];
          if (el == LG) e_long[b] = 1'b1;
          if (b == 5 && el > LG && ((el - LG) % RP) == 0) e_rep[b] = 1'b1;
        end
      end
      e_level[b] = m_level[b];
    end
    n_edge++;
  endtask

  task automatic step(input bit rst, input logic [5:0] raw);
    logic [2:0] sp;
    logic [2:0] exp_sp;
    reset     = rst;
    menu_raw  = raw[0];
    speed_raw = raw[3:1];
    clean_raw = raw[4];
    inc_raw   = raw[5];
    @(posedge clk);
    model_edge(rst, raw);
    #1;
    sp = e_press[3:1];
    if (sp[0])      exp_sp = 3'b001;
    else if (sp[1]) exp_sp = 3'b010;
    else if (sp[2]) exp_sp = 3'b100;
    else            exp_sp = 3'b000;
    check("btn_level",    {26'd0, btn_level},   {26'd0, e_level});
    check("btn_release",  {26'd0, btn_release}, {26'd0, e_rel});
    check("btn_long",     {26'd0, btn_long},    {26'd0, e_long});
    check("menu_btn",     {31'd0, menu_btn},    {31'd0, e_press[0]});
    check("clean_btn",    {31'd0, clean_btn},   {31'd0, e_press[4]});
    check("speed_btn",    {29'd0, speed_btn},   {29'd0, exp_sp});
    check("increase_key", {31'd0, increase_key}, {31'd0, (e_press[5] | e_rep[5])});
  endtask

  initial begin
    logic [5:0] raw;
    logic [2:0] spd_seen;
    int first, cnt, lg, rel_cnt, div;

    for (int i = 0; i < 3; i++) step(1'b1, 6'b000000);
    for (int i = 0; i < 4; i++) step(1'b0, 6'b000000);

    // Clean menu press
    first = -1; cnt = 0; lg = -1; rel_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      step(1'b0, 6'b000001);
      if (menu_btn) begin
        cnt++;
        if (first < 0) first = k;
      end
      if (btn_long[0] && lg < 0) lg = k;
      if (btn_release != 6'b0) rel_cnt++;
    end
    check("clean_press_edge",  first, 6);
    check("clean_press_count", cnt, 1);
    check("clean_long_edge",   lg, 22);
    check("clean_no_release",  rel_cnt, 0);
    for (int i = 0; i < 12; i++) step(1'b0, 6'b000000);

    // Glitch shorter than the debounce window
    cnt = 0;
    for (int k = 0; k < 15; k++) begin
      step(1'b0, (k < 3) ? 6'b010000 : 6'b000000);
      if (clean_btn || btn_level[4]) cnt++;
    end
    check("glitch_pulses", cnt, 0);

    // Bouncing inc, then held long enough to auto-repeat, then released
    cnt = 0; lg = 0; rel_cnt = 0;
    for (int k = 0; k < 72; k++) begin
      if (k < 5)       raw = (k % 2 == 0) ? 6'b100000 : 6'b000000;
      else if (k < 60) raw = 6'b100000;
      else             raw = 6'b000000;
      step(1'b0, raw);
      if (k < 12 && increase_key) cnt++;
      if (btn_long[5]) lg++;
      if (btn_release[5]) rel_cnt++;
    end
    check("bounce_press_count", cnt, 1);
    check("inc_long_count",     lg, 1);
    check("inc_release_count",  rel_cnt, 1);

    // Two speed buttons in the same cycle
    spd_seen = 3'b000;
    for (int k = 0; k < 12; k++) begin
      step(1'b0, 6'b001100);
      spd_seen = spd_seen | speed_btn;
    end
    check("speed_collision", {29'd0, spd_seen}, 32'd2);
    check("speed_levels",    {29'd0, btn_level[3:1]}, 32'd6);
    for (int i = 0; i < 12; i++) step(1'b0, 6'b000000);

    // Reset while menu is held
    rel_cnt = 0;
    for (int k = 0; k < 10; k++) step(1'b0, 6'b000001);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 6'b000001);
      check("reset_outputs", {btn_level, btn_release, btn_long, menu_btn, speed_btn, clean_btn, increase_key}, 32'd0);
    end
    first = -1;
    for (int k = 1; k <= 12; k++) begin
      step(1'b0, 6'b000001);
      if (menu_btn && first < 0) first = k;
      if (btn_release[0]) rel_cnt++;
    end
    check("reset_repress_edge", first, 6);
    check("reset_no_release",   rel_cnt, 0);
    for (int i = 0; i < 12; i++) step(1'b0, 6'b000000);

    // Random bouncing in segments of varying activity, with rare resets
    raw = 6'b000000;
    for (int seg = 0; seg < 60; seg++) begin
      case ($urandom_range(2))
        0:       div = 3;
        1:       div = 10;
        default: div = 40;
      endcase
      for (int k = 0; k < 40; k++) begin
        for (int b = 0; b < NB; b++) begin
          if ($urandom_range(div - 1) == 0) raw[b] = !raw[b];
        end
        step(($urandom_range(299) == 0), raw);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
